reg_scoreboard: RTL
===================

// Module: reg_scoreboard
// PURPOSE
//   Register-file hazard controller for the instruction-decode stage.
//   Tracks destination registers of instructions still in flight, and stalls decode while a needed
//   source register is pending. Writeback releases the register. Sits between decode, reg_file and writeback.
// PARAMETERS
//   NUM_REGS  32  architectural registers; register 0 is hard-wired zero and is never tracked
//   ADDR_W    5   register index width, equal to clog2(NUM_REGS)
//   CNT_W     2   per-register pending-write counter width; CMAX = 2**CNT_W-1
// PORTS
//   clk            in   1       clock, rising edge
//   rst            in   1       asynchronous reset, active-high
//   id_valid       in   1       decode offers an instruction this cycle
//   id_ready       out  1       scoreboard accepts it; issue = id_valid & id_ready
//   id_rs1         in   ADDR_W  source 1 index
//   id_rs1_used    in   1       instruction reads rs1
//   id_rs2         in   ADDR_W  source 2 index
//   id_rs2_used    in   1       instruction reads rs2
//   id_rd          in   ADDR_W  destination index
//   id_rd_wen      in   1       instruction writes rd
//   wb_valid       in   1       writeback retires a write this cycle
//   wb_rd          in   ADDR_W  writeback destination index
//   flush          in   1       pipeline flush; kills all in-flight tracking
//   stall_cnt      out  32      number of cycles in which decode was stalled, saturating
//   err_underflow  out  1       sticky: writeback to a register with a pending count of 0
// BEHAVIOUR
//   - Reset, async: all cnt[r] = 0, stall_cnt = 0, err_underflow = 0. id_ready is then 1 unless flush = 1.
//   - src_hz(s) = used & s != 0 & cnt[s] != 0.
//   - Waw_full = id_rd_wen & id_rd != 0 & cnt[id_rd] == CMAX.
//   - id_ready = !flush & !src_hz(rs1) & !src_hz(rs2) & !waw_full. id_ready is combinational and has no dependence on id_valid.
//   - Update per register r != 0, at the clock edge:
//     - inc = issue & id_rd_wen & id_rd == r.
//     - dec = wb_valid & wb_rd == r & cnt[r] != 0.
//     - cnt[r] <= cnt[r] + inc - dec.
//     - When inc and dec occur on the same register in the same cycle, the count is unchanged.
//   - Latency:
//     - Issue at edge k makes the register busy from cycle k+1 onward.
//     - Writeback at edge k frees the register. A dependent instruction can issue in cycle k+1.
//   - Writes to register 0, from issue or writeback, are ignored. cnt[0] is constant 0.
//   - Count saturation: cnt never exceeds CMAX, because waw_full blocks the issue.
//   - Underflow: wb_valid & wb_rd != 0 & cnt[wb_rd] == 0 & !flush sets err_underflow. The count stays at 0.
//   - Flush has priority over issue and writeback:
//     - All counts go to 0 at the next edge.
//     - id_ready = 0 during the flush cycle.
//     - A writeback in the same cycle is dropped without an error.
//     - After the flush, stale writebacks to a count of 0 set err_underflow. The system flow must drain writeback first.
//   - stall_cnt: +1 each cycle with id_valid & !id_ready & !flush. It holds at 32'hFFFF_FFFF.
//   - err_underflow clears only on reset.
//   - Reset mid-operation: all state clears immediately, and pending counts are lost.
// CONFIGURATION
//   SCB_BYPASS_EN defined:
//     - A source is not a hazard if cnt[s] == 1 & wb_valid & wb_rd == s in the same cycle.
//     - This allows same-cycle issue, with the writeback data forwarded to reg_file.
//     - A simultaneous issue writing that s still nets the count to 1.
//   SCB_BYPASS_EN undefined:
//     - There is no bypass. The dependent instruction issues one cycle after writeback.
// TESTING
//   T1 after reset: id_valid=1, rs1=5 used -> id_ready=1; stall_cnt=0; err_underflow=0
//   T2 issue rd=3 wen; next cycle rs1=3 used -> id_ready=0, stall_cnt increments each cycle;
//      wb_rd=3 -> id_ready=1 next cycle (bypass off) or same cycle (SCB_BYPASS_EN)
//   T3 issue rd=7 three times (CNT_W=2) -> cnt=3; fourth issue rd=7 -> id_ready=0;
//      one wb_rd=7 -> fourth issue accepted
//   T4 issue rd=4 and wb_rd=4 in same cycle with cnt[4]=1 -> cnt[4] stays 1; rd=0 / wb_rd=0 -> no change, no error
//   T5 flush with cnt[2]=2, cnt[9]=1 -> id_ready=0 that cycle, all counts 0 next cycle; then wb_rd=9 -> err_underflow=1 sticky until rst
//   T6 assert rst async mid-stall -> id_ready=1, stall_cnt=0 immediately, without waiting for a clock edge

Source files
------------

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: register-file hazard controller for the instruction-decode stage.
//
// Tracks the destination registers of in-flight instructions with a small pending-write
// counter per register. Decode is held off while a source it reads is still pending, or while
// its destination counter is already full. Writeback releases one pending write per cycle.
// Register 0 is hard-wired zero and is never tracked.
//
// Optional feature (macro SCB_BYPASS_EN):
//   defined   - a source whose only pending write retires this cycle is not a hazard, so the
//               dependent instruction issues in the same cycle as the writeback (data forwarded).
//   undefined - no bypass; the dependent instruction issues the cycle after writeback.
//
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-high reset
//   id_valid / id_ready       decode handshake; issue = id_valid & id_ready
//   id_rs1, id_rs1_used       source 1 index and read enable
//   id_rs2, id_rs2_used       source 2 index and read enable
//   id_rd, id_rd_wen          destination index and write enable
//   wb_valid, wb_rd           writeback retiring a write to wb_rd
//   flush                     kill all in-flight tracking
//   stall_cnt                 saturating count of cycles decode was stalled
//   err_underflow             sticky: writeback to a register with no pending write
module reg_scoreboard #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned CNT_W    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [ADDR_W-1:0] id_rs1,
    input  logic              id_rs1_used,
    input  logic [ADDR_W-1:0] id_rs2,
    input  logic              id_rs2_used,
    input  logic [ADDR_W-1:0] id_rd,
    input  logic              id_rd_wen,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic              flush,
    output logic [31:0]       stall_cnt,
    output logic              err_underflow
);

    localparam logic [CNT_W-1:0] CMAX = '1;
    localparam logic [CNT_W-1:0] CONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q [NUM_REGS];
    logic [CNT_W-1:0] cnt_d [NUM_REGS];
    logic [31:0]      stall_q, stall_d;
    logic             err_q, err_d;

    logic rs1_hz, rs2_hz, waw_full, issue;

    // A source is a hazard when it is read, non-zero and still has a pending write.
    always_comb begin
        rs1_hz = id_rs1_used && (id_rs1 != '0) && (cnt_q[id_rs1] != '0);
        rs2_hz = id_rs2_used && (id_rs2 != '0) && (cnt_q[id_rs2] != '0);
`ifdef SCB_BYPASS_EN
        // The last pending write retiring this cycle is forwarded, so it no longer blocks.
        if (cnt_q[id_rs1] == CONE && wb_valid && wb_rd == id_rs1) begin
            rs1_hz = 1'b0;
        end
        if (cnt_q[id_rs2] == CONE && wb_valid && wb_rd == id_rs2) begin
            rs2_hz = 1'b0;
        end
`endif
        waw_full = id_rd_wen && (id_rd != '0) && (cnt_q[id_rd] == CMAX);
        id_ready = !flush && !rs1_hz && !rs2_hz && !waw_full;
        issue    = id_valid && id_ready;
    end

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            logic inc_r;
            logic dec_r;
            inc_r    = 1'b0;
            dec_r    = 1'b0;
            cnt_d[r] = cnt_q[r];
            if (r != 0) begin
                if (flush) begin
                    cnt_d[r] = '0;
                end else begin
                    inc_r    = issue && id_rd_wen && (id_rd == ADDR_W'(r));
                    dec_r    = wb_valid && (wb_rd == ADDR_W'(r)) && (cnt_q[r] != '0);
                    cnt_d[r] = cnt_q[r] + {{(CNT_W-1){1'b0}}, inc_r}
                                        - {{(CNT_W-1){1'b0}}, dec_r};
                end
            end
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (id_valid && !id_ready && !flush && stall_q != 32'hFFFF_FFFF) begin
            stall_d = stall_q + 32'd1;
        end
        // A writeback dropped by flush is not an error; one arriving after it is.
        err_d = err_q;
        if (wb_valid && wb_rd != '0 && cnt_q[wb_rd] == '0 && !flush) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end

    assign stall_cnt     = stall_q;
    assign err_underflow = err_q;

endmodule
